identity_matrix_ctrl: RTL and testbench

IDENTITY_MATRIX_CTRL -- requirements
Module: identity_matrix_ctrl

---
 rtl/identity_matrix_ctrl.sv | 177 +++++++++++++++++
 tb/tb_identity_matrix_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/identity_matrix_ctrl.sv
// -----------------------------------------------------------------------------
// identity_matrix_ctrl
//
// Sequencer in front of a 4-word BRAM that stores a 2x2 single-precision
// matrix (word k = row*2+col lives at address k). It can load the identity
// matrix, write a caller-supplied matrix, or read the whole matrix back and
// present it with a valid/ready handshake.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   init_start          pulse: write identity (ONE_WORD on the diagonal)
//   wr_valid, wr_matrix request to write a full matrix (word k at [32k+31:32k])
//   rd_req              pulse: fetch the full matrix
//   mat_out, mat_valid  fetched matrix and its valid flag
//   mat_ready           consumer accepts mat_out
//   busy                high whenever the sequencer is not idle
//   init_done           one-cycle pulse after the identity load completes
//   *_identity_A        BRAM port A (enable, write enable, address, data)
// -----------------------------------------------------------------------------
module identity_matrix_ctrl #(
    parameter int          RD_LATENCY = 2,
    parameter logic [31:0] ONE_WORD   = 32'h3F800000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_start,
    input  logic         wr_valid,
    input  logic [127:0] wr_matrix,
    input  logic         rd_req,
    output logic [127:0] mat_out,
    output logic         mat_valid,
    input  logic         mat_ready,
    output logic         busy,
    output logic         init_done,
    output logic         ena_identity_A,
    output logic         wea_identity_A,
    output logic [1:0]   addra_identity_A,
    output logic [31:0]  dina_identity_A,
    input  logic [31:0]  douta_identity_A
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WRITE,
        RD_ISSUE,
        RD_DRAIN,
        HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    cnt;
    logic [127:0]  wr_buf;
    logic [31:0]   slot [4];
    logic          last_cap;

    // Read tag pipeline: one entry per BRAM latency cycle, carrying whether a
    // read was issued and which word it targets, so douta lands in the right slot.
    logic [RD_LATENCY-1:0] tag_vld;
    logic [1:0]            tag_idx [RD_LATENCY];

    logic accept_wr;
    assign accept_wr = (state == IDLE) && !init_start && wr_valid;

    // -------------------------------------------------------------------------
    // Next state and BRAM port drive
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_nxt        = state;
        ena_identity_A   = 1'b0;
        wea_identity_A   = 1'b0;
        addra_identity_A = 2'd0;
        dina_identity_A  = 32'd0;

        unique case (state)
            IDLE: begin
                if (init_start)    state_nxt = INIT;
                else if (wr_valid) state_nxt = WRITE;
                else if (rd_req)   state_nxt = RD_ISSUE;
            end
            INIT: begin
                ena_identity_A   = 1'b1;
                wea_identity_A   = 1'b1;
                addra_identity_A = cnt;
                // Addresses 0 and 3 are the diagonal of the 2x2 matrix.
                dina_identity_A  = (cnt == 2'd0 || cnt == 2'd3) ? ONE_WORD : 32'd0;
                if (cnt == 2'd3) state_nxt = IDLE;
            end
            WRITE: begin
                ena_identity_A   = 1'b1;
                wea_identity_A   = 1'b1;
                addra_identity_A = cnt;
                dina_identity_A  = wr_buf[{cnt, 5'd0} +: 32];
                if (cnt == 2'd3) state_nxt = IDLE;
            end
            RD_ISSUE: begin
                ena_identity_A   = 1'b1;
                addra_identity_A = cnt;
                if (cnt == 2'd3) state_nxt = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (last_cap) state_nxt = HOLD;
            end
            HOLD: begin
                if (mat_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // State, address counter, write buffer, status flags
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            wr_buf    <= '0;
            init_done <= 1'b0;
            mat_valid <= 1'b0;
            mat_out   <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= (state == INIT) && (cnt == 2'd3);

            // The counter only advances while sweeping addresses; its 3->0
            // wrap coincides with leaving the sweeping state.
            if (state == INIT || state == WRITE || state == RD_ISSUE)
                cnt <= cnt + 2'd1;
            else
                cnt <= 2'd0;

            if (accept_wr)
                wr_buf <= wr_matrix;

            if (state == RD_DRAIN && last_cap) begin
                mat_out   <= {slot[3], slot[2], slot[1], slot[0]};
                mat_valid <= 1'b1;
            end else if (state == HOLD && mat_ready) begin
                mat_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read capture: tags travel alongside the BRAM latency and steer douta
    // -------------------------------------------------------------------------
    // NOTE: the four-word capture buffer is reset along with the tags so a
    // read aborted by reset can never leak stale words into a later result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld  <= '0;
            last_cap <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) tag_idx[i] <= 2'd0;
            for (int k = 0; k < 4; k++)          slot[k]    <= 32'd0;
        end else begin
            tag_vld[0] <= (state == RD_ISSUE);
            tag_idx[0] <= cnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end

            if (tag_vld[RD_LATENCY-1])
                slot[tag_idx[RD_LATENCY-1]] <= douta_identity_A;

            last_cap <= tag_vld[RD_LATENCY-1] && (tag_idx[RD_LATENCY-1] == 2'd3);
        end
    end

endmodule

// File: tb/tb_identity_matrix_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for identity_matrix_ctrl. Two instances share every command
// input: one with the default BRAM read latency (2) and one with latency 3,
// each attached to its own behavioural BRAM. Expected BRAM writes and
// expected read results are queued when a command is issued; monitors pop
// and compare when the DUT drives a write or raises mat_valid.
// -----------------------------------------------------------------------------
module tb_identity_matrix_ctrl;

    localparam logic [31:0]  ONE   = 32'h3F800000;
    localparam logic [127:0] IDENT = {ONE, 32'd0, 32'd0, ONE};

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        logic [127:0] mat;
        int           cyc;
    } rd_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         init_start, wr_valid, rd_req, mat_ready;
    logic [127:0] wr_matrix;

    logic [127:0] mat_out_a, mat_out_b;
    logic         mat_valid_a, mat_valid_b, busy_a, busy_b, idone_a, idone_b;
    logic         ena_a, ena_b, wea_a, wea_b;
    logic [1:0]   addr_a, addr_b;
    logic [31:0]  din_a, din_b, dout_a, dout_b;

    identity_matrix_ctrl #(.RD_LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .init_start(init_start), .wr_valid(wr_valid),
        .wr_matrix(wr_matrix), .rd_req(rd_req), .mat_out(mat_out_a),
        .mat_valid(mat_valid_a), .mat_ready(mat_ready), .busy(busy_a),
        .init_done(idone_a), .ena_identity_A(ena_a), .wea_identity_A(wea_a),
        .addra_identity_A(addr_a), .dina_identity_A(din_a),
        .douta_identity_A(dout_a)
    );

    identity_matrix_ctrl #(.RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .init_start(init_start), .wr_valid(wr_valid),
        .wr_matrix(wr_matrix), .rd_req(rd_req), .mat_out(mat_out_b),
        .mat_valid(mat_valid_b), .mat_ready(mat_ready), .busy(busy_b),
        .init_done(idone_b), .ena_identity_A(ena_b), .wea_identity_A(wea_b),
        .addra_identity_A(addr_b), .dina_identity_A(din_b),
        .douta_identity_A(dout_b)
    );

    // Behavioural BRAMs: address registered at the edge, then L-1 output stages.
    logic [31:0] mem_a [4];
    logic [31:0] rp_a  [2];
    logic [31:0] mem_b [4];
    logic [31:0] rp_b  [3];

    always @(posedge clk) begin
        if (ena_a && wea_a)  mem_a[addr_a] <= din_a;
        if (ena_a && !wea_a) rp_a[0] <= mem_a[addr_a];
        rp_a[1] <= rp_a[0];
        if (ena_b && wea_b)  mem_b[addr_b] <= din_b;
        if (ena_b && !wea_b) rp_b[0] <= mem_b[addr_b];
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end
    assign dout_a = rp_a[1];
    assign dout_b = rp_b[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboards and event counters
    wr_exp_t wq[$];
    rd_exp_t rq_a[$];
    rd_exp_t rq_b[$];
    int      busy_cnt  = 0;
    int      idone_cnt = 0;
    int      rd_cnt    = 0;

    always @(negedge clk) begin
        if (busy_a)  busy_cnt++;
        if (idone_a) idone_cnt++;
        if (ena_a && !wea_a) rd_cnt++;
    end

    // Write monitor (port A of the default instance)
    always @(negedge clk) begin
        wr_exp_t e;
        if (!rst && ena_a && wea_a) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = wq.pop_front();
                check("wr_addr", addr_a, e.addr);
                check("wr_data", din_a, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
        if (ena_a && !wea_a && din_a != 32'd0) check("rd_dina_zero", din_a, 0);
    end

    // Result monitors: compare on mat_valid rise, then check stability while held.
    logic         pv_a = 1'b0, pv_b = 1'b0;
    logic [127:0] held_a, held_b;

    always @(negedge clk) begin
        rd_exp_t e;
        if (mat_valid_a && !pv_a) begin
            if (rq_a.size() == 0) check("unexpected_valid_a", 1, 0);
            else begin
                e = rq_a.pop_front();
                check("mat_out_a", mat_out_a, e.mat);
                check("valid_cycle_a", cyc, e.cyc);
            end
            held_a = mat_out_a;
        end else if (mat_valid_a && pv_a) begin
            check("hold_stable_a", mat_out_a, held_a);
        end
        pv_a = mat_valid_a;
    end

    always @(negedge clk) begin
        rd_exp_t e;
        if (mat_valid_b && !pv_b) begin
            if (rq_b.size() == 0) check("unexpected_valid_b", 1, 0);
            else begin
                e = rq_b.pop_front();
                check("mat_out_b", mat_out_b, e.mat);
                check("valid_cycle_b", cyc, e.cyc);
            end
            held_b = mat_out_b;
        end else if (mat_valid_b && pv_b) begin
            check("hold_stable_b", mat_out_b, held_b);
        end
        pv_b = mat_valid_b;
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic i, input logic w, input logic r, output int n);
        @(negedge clk);
        n          = cyc;
        init_start = i;
        wr_valid   = w;
        rd_req     = r;
    endtask

    task automatic drop_cmds();
        @(negedge clk);
        init_start = 1'b0;
        wr_valid   = 1'b0;
        rd_req     = 1'b0;
    endtask

    task automatic push_words(input logic [127:0] m, input int n);
        for (int k = 0; k < 4; k++) begin
            wr_exp_t e;
            e.addr = 2'(k);
            e.data = m[32*k +: 32];
            e.cyc  = n + 1 + k;
            wq.push_back(e);
        end
    endtask

    task automatic push_read(input logic [127:0] m, input int n);
        rd_exp_t e;
        e.mat = m;
        e.cyc = n + 8;   // T0+7 with latency 2, T0 = edge after cycle n
        rq_a.push_back(e);
        e.cyc = n + 9;   // T0+8 with latency 3
        rq_b.push_back(e);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy_a && !busy_b) return;
        end
        check("idle_timeout", 1, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int           n, bc, ic, rc;
        logic [127:0] wm;

        rst        = 1'b1;
        init_start = 1'b0;
        wr_valid   = 1'b0;
        rd_req     = 1'b0;
        mat_ready  = 1'b0;
        wr_matrix  = '0;

        repeat (3) @(negedge clk);
        check("rst_mat_out_a", mat_out_a, 0);
        check("rst_mat_out_b", mat_out_b, 0);
        check("rst_ctrl_a", {mat_valid_a, busy_a, idone_a, ena_a, wea_a}, 0);
        check("rst_ctrl_b", {mat_valid_b, busy_b, idone_b, ena_b, wea_b}, 0);
        check("rst_port_a", {addr_a, din_a}, 0);
        check("rst_port_b", {addr_b, din_b}, 0);
        rst = 1'b0;

        // Identity load
        bc = busy_cnt;
        ic = idone_cnt;
        issue(1, 0, 0, n);
        push_words(IDENT, n);
        drop_cmds();
        wait_idle();
        repeat (2) @(negedge clk);
        check("init_busy_cycles", busy_cnt - bc, 4);
        check("init_done_pulses", idone_cnt - ic, 1);

        // Read identity with consumer always ready
        mat_ready = 1'b1;
        issue(0, 0, 1, n);
        push_read(IDENT, n);
        drop_cmds();
        wait_idle();

        // Write a matrix, then read it with backpressure
        wm        = {32'hDEADBEEF, 32'h12345678, 32'h00000000, ONE};
        wr_matrix = wm;
        ic        = idone_cnt;
        issue(0, 1, 0, n);
        push_words(wm, n);
        drop_cmds();
        wait_idle();
        repeat (2) @(negedge clk);
        check("write_no_init_done", idone_cnt - ic, 0);

        mat_ready = 1'b0;
        issue(0, 0, 1, n);
        push_read(wm, n);
        drop_cmds();
        repeat (20) @(negedge clk);
        check("held_valid_busy_a", {mat_valid_a, busy_a}, 2'b11);
        check("held_valid_busy_b", {mat_valid_b, busy_b}, 2'b11);
        mat_ready = 1'b1;
        @(negedge clk);
        mat_ready = 1'b0;
        check("handshake_clear_a", {mat_valid_a, busy_a}, 2'b00);
        check("handshake_clear_b", {mat_valid_b, busy_b}, 2'b00);
        check("mat_out_kept_a", mat_out_a, wm);
        check("mat_out_kept_b", mat_out_b, wm);

        // Simultaneous commands: init wins; a read request during INIT is dropped
        ic = idone_cnt;
        rc = rd_cnt;
        issue(1, 1, 1, n);
        push_words(IDENT, n);
        drop_cmds();
        rd_req = 1'b1;
        repeat (2) @(negedge clk);
        rd_req = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("arb_no_reads", rd_cnt - rc, 0);
        check("arb_init_done", idone_cnt - ic, 1);

        // Reset in the second RD_ISSUE cycle, then a read right after release
        mat_ready = 1'b1;
        issue(0, 0, 1, n);
        drop_cmds();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ctrl_a", {mat_valid_a, busy_a, idone_a, ena_a, wea_a}, 0);
        check("abort_ctrl_b", {mat_valid_b, busy_b, idone_b, ena_b, wea_b}, 0);
        check("abort_port_a", {addr_a, din_a}, 0);
        check("abort_mat_out_a", mat_out_a, 0);
        repeat (3) @(negedge clk);
        n      = cyc;
        rst    = 1'b0;
        rd_req = 1'b1;
        push_read(IDENT, n);
        drop_cmds();
        wait_idle();
        repeat (3) @(negedge clk);

        check("wr_queue_drained", wq.size(), 0);
        check("rd_queue_a_drained", rq_a.size(), 0);
        check("rd_queue_b_drained", rq_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
